// File: rtl/hash_seg_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hash_seg_packer                                               |
// | Brief    : Packs variable-length byte beats into a 32-bit word BRAM for  |
// |            the hash core, launches the hash, captures the digest and     |
// |            serves it by address.                                         |
// | Macro    : HASH_PACK_PREFIX_EN - prepend the PREFIX domain byte.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hash_seg_packer #(
   parameter int         IN_W             = 288,
   parameter int         DEPTH            = 512,
   parameter int         HASH_OUTPUT_SIZE = 256,
   parameter logic [7:0] PREFIX           = 8'h02
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic                                  i_start,
   output logic                                  o_done,
   input  logic [IN_W-1:0]                       i_data,
   input  logic [$clog2(IN_W/8+1)-1:0]           i_bytes,
   input  logic                                  i_last,
   input  logic                                  i_valid,
   output logic                                  o_ready,
   output logic                                  o_overflow,
   output logic [31:0]                           o_hash_data_in,
   input  logic [$clog2(DEPTH)-1:0]              i_hash_addr,
   input  logic                                  i_hash_rd_en,
   input  logic [31:0]                           i_hash_data_out,
   input  logic                                  i_hash_data_out_valid,
   output logic                                  o_hash_data_out_ready,
   output logic [31:0]                           o_hash_input_length,
   output logic [31:0]                           o_hash_output_length,
   output logic                                  o_hash_start,
   output logic                                  o_hash_force_done,
   input  logic                                  i_hash_force_done_ack,
   input  logic [$clog2(HASH_OUTPUT_SIZE/32)-1:0] i_dig_addr,
   input  logic                                  i_dig_rd,
   output logic [31:0]                           o_dig
);

   localparam int c_NB   = IN_W / 8;
   localparam int c_BW   = $clog2(c_NB + 1);
   localparam int c_AW   = $clog2(DEPTH);
   localparam int c_NDIG = HASH_OUTPUT_SIZE / 32;
   localparam int c_DW   = $clog2(c_NDIG);
   localparam int c_CAP  = 4 * DEPTH;
   localparam int c_CW   = $clog2(c_CAP + 1);

   localparam logic [3:0] c_ST_IDLE   = 4'd0;
   localparam logic [3:0] c_ST_PREFIX = 4'd1;
   localparam logic [3:0] c_ST_LOAD   = 4'd2;
   localparam logic [3:0] c_ST_SHIFT  = 4'd3;
   localparam logic [3:0] c_ST_FLUSH  = 4'd4;
   localparam logic [3:0] c_ST_HSTART = 4'd5;
   localparam logic [3:0] c_ST_DIGEST = 4'd6;
   localparam logic [3:0] c_ST_FORCE  = 4'd7;
   localparam logic [3:0] c_ST_DONE   = 4'd8;

   logic [3:0]      r_state;
   logic [3:0]      w_next;
   logic [c_CW-1:0] r_cnt;
   logic [31:0]     r_acc;
   logic [IN_W-1:0] r_sh;
   logic [c_BW-1:0] r_rem;
   logic            r_last;
   logic            r_ovf;
   logic [31:0]     r_len;
   logic [c_DW-1:0] r_dcnt;
   logic [31:0]     r_dig [c_NDIG];
   logic [31:0]     r_mem [DEPTH];
   logic [31:0]     r_rdata;
   logic [31:0]     r_dig_q;

   logic [7:0]      w_byte;
   logic [1:0]      w_lane;
   logic            w_room;
   logic            w_we;
   logic [c_AW-1:0] w_waddr;
   logic [31:0]     w_wdata;

   assign w_byte = r_sh[7:0];
   assign w_lane = r_cnt[1:0];
   assign w_room = (r_cnt < c_CW'(c_CAP));

`ifndef HASH_PACK_PREFIX_EN
   logic w_unused_prefix;
   assign w_unused_prefix = ^PREFIX;
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= c_ST_IDLE;
      else          r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE:   if (i_start) begin
`ifdef HASH_PACK_PREFIX_EN
                         w_next = c_ST_PREFIX;
`else
                         w_next = c_ST_LOAD;
`endif
                      end
         c_ST_PREFIX: w_next = c_ST_LOAD;
         c_ST_LOAD:   if (i_valid) begin
                         if (i_bytes != '0)  w_next = c_ST_SHIFT;
                         else if (i_last)    w_next = c_ST_FLUSH;
                      end
         c_ST_SHIFT:  if (r_rem == c_BW'(1)) w_next = r_last ? c_ST_FLUSH : c_ST_LOAD;
         c_ST_FLUSH:  w_next = c_ST_HSTART;
         c_ST_HSTART: w_next = c_ST_DIGEST;
         c_ST_DIGEST: if (i_hash_data_out_valid && (r_dcnt == c_DW'(c_NDIG - 1)))
                         w_next = c_ST_FORCE;
         c_ST_FORCE:  if (i_hash_force_done_ack) w_next = c_ST_DONE;
         c_ST_DONE:   w_next = c_ST_IDLE;
         default:     w_next = c_ST_IDLE;
      endcase
   end

   // State-decoded handshake outputs
   always_comb begin
      o_ready               = (r_state == c_ST_LOAD);
      o_hash_start          = (r_state == c_ST_HSTART);
      o_hash_data_out_ready = (r_state == c_ST_DIGEST);
      o_hash_force_done     = (r_state == c_ST_FORCE);
      o_done                = (r_state == c_ST_DONE);
   end

   // BRAM write port: full word on lane-3 shift, partial word on flush
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_cnt[c_AW+1:2];
      w_wdata = r_acc;
      if (r_state == c_ST_SHIFT && w_room && w_lane == 2'd3) begin
         w_we    = 1'b1;
         w_wdata = {w_byte, r_acc[23:0]};
      end else if (r_state == c_ST_FLUSH && w_lane != 2'd0) begin
         w_we    = 1'b1;
      end
   end

   // Packing datapath, length capture and digest capture
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_sh   <= '0;
         r_rem  <= '0;
         r_last <= 1'b0;
         r_ovf  <= 1'b0;
         r_len  <= '0;
         r_dcnt <= '0;
         for (int k = 0; k < c_NDIG; k++) r_dig[k] <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: if (i_start) begin
               r_cnt  <= '0;
               r_acc  <= '0;
               r_ovf  <= 1'b0;
               r_dcnt <= '0;
               r_len  <= '0;
            end
`ifdef HASH_PACK_PREFIX_EN
            c_ST_PREFIX: begin
               r_acc[7:0] <= PREFIX;
               r_cnt      <= c_CW'(1);
            end
`endif
            c_ST_LOAD: if (i_valid) begin
               r_sh   <= i_data;
               r_rem  <= i_bytes;
               r_last <= i_last;
            end
            c_ST_SHIFT: begin
               r_sh  <= r_sh >> 8;
               r_rem <= r_rem - c_BW'(1);
               if (w_room) begin
                  r_cnt <= r_cnt + c_CW'(1);
                  // A completed word goes to BRAM, so the lanes restart from zero
                  case (w_lane)
                     2'd0: r_acc[7:0]   <= w_byte;
                     2'd1: r_acc[15:8]  <= w_byte;
                     2'd2: r_acc[23:16] <= w_byte;
                     default: r_acc     <= '0;
                  endcase
               end else begin
                  r_ovf <= 1'b1;
               end
            end
            c_ST_FLUSH: r_len <= {{(32-c_CW-3){1'b0}}, r_cnt, 3'b000};
            c_ST_DIGEST: if (i_hash_data_out_valid) begin
               r_dig[r_dcnt] <= i_hash_data_out;
               r_dcnt        <= r_dcnt + c_DW'(1);
            end
            default: ;
         endcase
      end
   end

   // Word BRAM storage (contents undefined after reset)
   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   // One-cycle read ports for the hash core and digest consumer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
         r_dig_q <= '0;
      end else begin
         if (i_hash_rd_en) r_rdata <= r_mem[i_hash_addr];
         if (i_dig_rd)     r_dig_q <= r_dig[i_dig_addr];
      end
   end

   assign o_overflow           = r_ovf;
   assign o_hash_data_in       = r_rdata;
   assign o_hash_input_length  = r_len;
   assign o_hash_output_length = 32'(HASH_OUTPUT_SIZE);
   assign o_dig                = r_dig_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_seg_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hash_seg_packer                                            |
// | Brief    : Scoreboard bench for hash_seg_packer; a full-size instance    |
// |            and a DEPTH=4 instance run the same jobs in lockstep.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hash_seg_packer;
   localparam int IN_W = 288, NB = 36, BW = 6, DEPTH = 512, AW = 9;
   localparam int S_DEPTH = 4, S_AW = 2, NDIG = 8, DGW = 3;
   localparam logic [7:0] PFX = 8'h02;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic start = 0, last = 0, valid = 0, hash_rd_en = 0, hash_dv = 0, force_ack = 0, dig_rd = 0;
   logic [IN_W-1:0] data = '0;
   logic [BW-1:0]   nbytes = '0;
   logic [AW-1:0]   hash_addr = '0;
   logic [31:0]     hash_dout = '0;
   logic [DGW-1:0]  dig_addr = '0;

   logic done, ready, ovf, hdr, hstart, fdone;
   logic [31:0] hdin, len, olen, dig;
   logic s_done, s_ready, s_ovf, s_hdr, s_hstart, s_fdone;
   logic [31:0] s_hdin, s_len, s_olen, s_dig;

   hash_seg_packer #(.IN_W(IN_W), .DEPTH(DEPTH), .HASH_OUTPUT_SIZE(256), .PREFIX(PFX)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_done(done), .i_data(data),
      .i_bytes(nbytes), .i_last(last), .i_valid(valid), .o_ready(ready), .o_overflow(ovf),
      .o_hash_data_in(hdin), .i_hash_addr(hash_addr), .i_hash_rd_en(hash_rd_en),
      .i_hash_data_out(hash_dout), .i_hash_data_out_valid(hash_dv),
      .o_hash_data_out_ready(hdr), .o_hash_input_length(len), .o_hash_output_length(olen),
      .o_hash_start(hstart), .o_hash_force_done(fdone), .i_hash_force_done_ack(force_ack),
      .i_dig_addr(dig_addr), .i_dig_rd(dig_rd), .o_dig(dig));

   hash_seg_packer #(.IN_W(IN_W), .DEPTH(S_DEPTH), .HASH_OUTPUT_SIZE(256), .PREFIX(PFX)) sdut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_done(s_done), .i_data(data),
      .i_bytes(nbytes), .i_last(last), .i_valid(valid), .o_ready(s_ready), .o_overflow(s_ovf),
      .o_hash_data_in(s_hdin), .i_hash_addr(hash_addr[S_AW-1:0]), .i_hash_rd_en(hash_rd_en),
      .i_hash_data_out(hash_dout), .i_hash_data_out_valid(hash_dv),
      .o_hash_data_out_ready(s_hdr), .o_hash_input_length(s_len), .o_hash_output_length(s_olen),
      .o_hash_start(s_hstart), .o_hash_force_done(s_fdone), .i_hash_force_done_ack(force_ack),
      .i_dig_addr(dig_addr), .i_dig_rd(dig_rd), .o_dig(s_dig));

   int total = 0, bad = 0;
   logic [7:0]  q_bytes[$];
   logic [31:0] q_exp[$], q_sexp[$], q_dig[$];

   function automatic logic [31:0] word_at(int w, int lim);
      logic [31:0] r = '0;
      for (int b = 0; b < 4; b++)
         if (4*w + b < lim) r[8*b +: 8] = q_bytes[4*w + b];
      return r;
   endfunction

   task automatic start_job();
      start = 1; @(negedge clk); start = 0;
      q_bytes.delete();
`ifdef HASH_PACK_PREFIX_EN
      q_bytes.push_back(PFX);
`endif
      total++;
      if ({ovf, s_ovf} !== 2'b00) begin bad++; $display("FAIL ovf_clear: got %b want 00", {ovf, s_ovf}); end
   endtask

   task automatic send_beat(input logic [IN_W-1:0] d, input int n, input bit lst);
      int guard = 0;
      while (!ready && guard < 200) begin @(negedge clk); guard++; end
      if (!ready) begin total++; bad++; $display("FAIL beat_wait: ready=%b want 1", ready); return; end
      data = d; nbytes = BW'(n); last = lst; valid = 1;
      for (int k = 0; k < n; k++) q_bytes.push_back(d[8*k +: 8]);
      @(negedge clk); valid = 0;
   endtask

   task automatic finish_job(input bit gap);
      int n, sn, nw, snw, guard;
      logic [31:0] e;
      n  = q_bytes.size();
      sn = (n > 4*S_DEPTH) ? 4*S_DEPTH : n;
      nw = (n + 3) / 4; snw = (sn + 3) / 4;
      for (int w = 0; w < nw; w++)  q_exp.push_back(word_at(w, n));
      for (int w = 0; w < snw; w++) q_sexp.push_back(word_at(w, sn));
      guard = 0;
      while (!hstart && guard < 500) begin @(negedge clk); guard++; end
      total++; if (hstart !== 1'b1) begin bad++; $display("FAIL hstart_wait: got %b want 1", hstart); end
      total++; if (s_hstart !== 1'b1) begin bad++; $display("FAIL s_hstart: got %b want 1", s_hstart); end
      total++; if (len !== 32'(8*n)) begin bad++; $display("FAIL length: got %0d want %0d", len, 8*n); end
      total++; if (s_len !== 32'(8*sn)) begin bad++; $display("FAIL s_length: got %0d want %0d", s_len, 8*sn); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL overflow: got %b want 0", ovf); end
      total++; if (s_ovf !== (n > sn)) begin bad++; $display("FAIL s_overflow: got %b want %b", s_ovf, n > sn); end
      @(negedge clk);
      total++; if (hstart !== 1'b0) begin bad++; $display("FAIL hstart_pulse: got %b want 0", hstart); end
      hash_rd_en = 1;
      for (int w = 0; w < nw; w++) begin
         hash_addr = AW'(w);
         @(negedge clk);
         e = q_exp.pop_front();
         total++; if (hdin !== e) begin bad++; $display("FAIL word%0d: got %h want %h", w, hdin, e); end
         if (w < snw) begin
            e = q_sexp.pop_front();
            total++; if (s_hdin !== e) begin bad++; $display("FAIL s_word%0d: got %h want %h", w, s_hdin, e); end
         end
      end
      hash_rd_en = 0;
      for (int i = 0; i < NDIG; i++) begin
         e = $urandom; q_dig.push_back(e);
         hash_dout = e; hash_dv = 1;
         total++; if ({hdr, s_hdr} !== 2'b11) begin bad++; $display("FAIL dig_ready: got %b want 11", {hdr, s_hdr}); end
         @(negedge clk); hash_dv = 0;
         if (gap) @(negedge clk);
      end
      guard = 0;
      while (!fdone && guard < 50) begin @(negedge clk); guard++; end
      @(negedge clk); @(negedge clk);
      total++; if ({fdone, s_fdone} !== 2'b11) begin bad++; $display("FAIL force_hold: got %b want 11", {fdone, s_fdone}); end
      force_ack = 1; @(negedge clk); force_ack = 0;
      total++; if ({done, s_done, fdone} !== 3'b110) begin bad++; $display("FAIL done_pulse: got %b want 110", {done, s_done, fdone}); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL done_clear: got %b want 0", done); end
      total++; if (len !== 32'(8*n)) begin bad++; $display("FAIL length_hold: got %0d want %0d", len, 8*n); end
      dig_rd = 1;
      for (int a = 0; a < NDIG; a++) begin
         dig_addr = DGW'(a);
         @(negedge clk);
         e = q_dig.pop_front();
         total++; if (dig !== e) begin bad++; $display("FAIL dig%0d: got %h want %h", a, dig, e); end
         total++; if (s_dig !== e) begin bad++; $display("FAIL s_dig%0d: got %h want %h", a, s_dig, e); end
      end
      dig_rd = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      total++;
      if ({done, ready, ovf, hdin, hdr, len, hstart, fdone, dig,
           s_done, s_ready, s_ovf, s_hdin, s_hdr, s_len, s_hstart, s_fdone, s_dig} !== '0) begin
         bad++; $display("FAIL %s_outputs: got nonzero want all 0 (len=%0d hdin=%h)", tag, len, hdin);
      end
      total++;
      if ({olen, s_olen} !== {32'd256, 32'd256}) begin
         bad++; $display("FAIL %s_outlen: got %0d want 256", tag, olen);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1; @(negedge clk);
      // valid outside LOAD must not be taken
      valid = 1; nbytes = BW'(4); @(negedge clk); @(negedge clk);
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %b want 0", ready); end
      valid = 0; nbytes = '0;
   endtask

   task automatic test_single_bytes();
      start_job();
      for (int i = 0; i < 16; i++) send_beat(IN_W'(i), 1, i == 15);
      finish_job(1);
   endtask

   task automatic test_full_beat();
      logic [IN_W-1:0] d;
      int lowc = 0;
      for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'($urandom);
      start_job();
      send_beat(d, NB, 0);
      while (!ready && lowc < 100) begin lowc++; @(negedge clk); end
      total++; if (lowc !== 36) begin bad++; $display("FAIL ready_low: got %0d want 36", lowc); end
      send_beat('0, 0, 1);
      finish_job(0);
   endtask

   task automatic test_overflow();
      logic [IN_W-1:0] d;
      for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'(8'h40 + k);
      start_job();
      send_beat(d, 7, 0);
      send_beat(d, 0, 0);
      send_beat(d >> 56, 13, 1);
      finish_job(1);
   endtask

   task automatic test_back_to_back();
      logic [IN_W-1:0] d;
      start_job();
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'($urandom);
         send_beat(d, int'($urandom_range(0, NB)), b == 5);
         if (b == 0) begin start = 1; @(negedge clk); start = 0; end
      end
      finish_job(0);
   endtask

   task automatic test_reset_mid();
      logic [IN_W-1:0] d;
      for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'($urandom);
      start_job();
      send_beat(d, NB, 0);
      repeat (5) @(negedge clk);
      rst_n = 0; #1;
      check_reset_outputs("midreset");
      @(negedge clk); rst_n = 1; @(negedge clk);
      start_job();
      send_beat(IN_W'(32'h44332211), 4, 1);
      finish_job(1);
   endtask

   task automatic test_aabbccdd();
      start_job();
      send_beat(IN_W'(32'hddccbbaa), 4, 1);
      finish_job(0);
   endtask

   initial begin
      test_reset();
      test_single_bytes();
      test_full_beat();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_aabbccdd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
